// File: rtl/uart_pixel_tx.sv
// uart_pixel_tx: pixel byte FIFO feeding an 8N1 serialiser, with frame counting.
// Optional `FRAME_HEADER_EN: each frame is preceded by SYNC_BYTE on the line.
module uart_pixel_tx #(
   parameter int         CLOCK_FREQ   = 50000000,
   parameter int         BAUD_RATE    = 115200,
   parameter int         FIFO_DEPTH   = 16,
   parameter int         FRAME_PIXELS = 76800,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        frame_done
);

   localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int PW   = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t state;
   state_t state_nx;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;

   logic [PW-1:0] pix_cnt;
   logic          cur_last;

   logic baud_done;
   logic pending;
   logic hdr_due;
   logic load;
   logic pop;
   logic push;
   logic last_pix;

   assign baud_done = (baud_cnt == CW'(CPB - 1));
   assign pending   = (fifo_count != '0);
   assign in_ready  = (fifo_count < CNTW'(FIFO_DEPTH));
   assign push      = in_valid & in_ready;
   assign last_pix  = (pix_cnt == PW'(FRAME_PIXELS - 1));

   // A new character starts from idle or straight out of a finished stop bit.
   assign load = pending &
                 ((state == IDLE) | ((state == STOP) & baud_done));

   // The header character is synthesised, so it leaves the FIFO untouched.
   assign pop = load & ~hdr_due;

`ifdef FRAME_HEADER_EN
   logic hdr_sent;

   assign hdr_due = (pix_cnt == '0) & ~hdr_sent;

   // Header is owed once per frame; re-armed when the frame's last pixel leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_sent <= 1'b0;
      end else if (load && hdr_due) begin
         hdr_sent <= 1'b1;
      end else if (pop && last_pix) begin
         hdr_sent <= 1'b0;
      end
   end
`else
   assign hdr_due = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state: every bit lasts CPB cycles, stop chains into the next start.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (pending) begin
               state_nx = START;
            end
         end
         START: begin
            if (baud_done) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (baud_done && (bit_cnt == 3'd7)) begin
               state_nx = STOP;
            end
         end
         STOP: begin
            if (baud_done) begin
               state_nx = pending ? START : IDLE;
            end
         end
      endcase
   end

   // FSM outputs: line level and busy follow the registered state directly.
   always_comb begin
      tx   = 1'b1;
      busy = (state != IDLE);
      unique case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[0];
         default: tx = 1'b1;
      endcase
   end

   // Baud and bit counters; both rest at zero outside their phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         if ((state == IDLE) || baud_done) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
         if (state != DATA) begin
            bit_cnt <= '0;
         end else if (baud_done) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   // Shift register: loaded on character start, shifted LSB-first per data bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= 8'hFF;
      end else if (load) begin
         shreg <= hdr_due ? SYNC_BYTE : mem[rd_ptr];
      end else if ((state == DATA) && baud_done) begin
         shreg <= {1'b1, shreg[7:1]};
      end
   end

   // FIFO storage needs no reset; only pointers define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNTW'(1);
            2'b01:   fifo_count <= fifo_count - CNTW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Refused write is flagged one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         overflow <= in_valid & ~in_ready;
      end
   end

   // Pixel counter: cur_last marks the in-flight character as the frame's end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt  <= '0;
         cur_last <= 1'b0;
      end else begin
         if (pop) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + PW'(1);
         end
         if (load) begin
            cur_last <= pop & last_pix;
         end
      end
   end

   // Frame pulse when the stop bit of the frame's last pixel completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state == STOP) & baud_done & cur_last;
      end
   end

endmodule

// File: tb/tb_uart_pixel_tx.sv
// tb_uart_pixel_tx: random and directed stimulus against a timing-level
// reference of the UART pixel transmitter, plus an independent line decoder.
module tb_uart_pixel_tx;

   localparam int DEPTH = 16;
   localparam int FP    = 4;
   localparam int CPB   = 10;
   localparam int CHAR  = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx;
   logic       busy;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       frame_done;

   uart_pixel_tx #(
      .CLOCK_FREQ  (1000000),
      .BAUD_RATE   (100000),
      .FIFO_DEPTH  (DEPTH),
      .FRAME_PIXELS(FP),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx        (tx),
      .busy      (busy),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: queue of buffered bytes and the character currently on the line.
   logic [7:0] q[$];
   int         cyc = 0;
   bit         m_act = 0;
   int         m_start = 0;
   logic [7:0] m_byte = 8'hFF;
   bit         m_last = 0;
   int         m_pix = 0;
   bit         m_hs = 0;
   bit         e_ovf = 0;
   bit         e_fd = 0;
   bit         hdue;
   int         pre;
   int         acc_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_act = 0;
         m_pix = 0;
         m_hs  = 0;
         m_last = 0;
         e_ovf = 0;
         e_fd  = 0;
      end else begin
         cyc++;
         if (in_valid && in_ready) acc_cnt++;
         pre   = q.size();
         e_ovf = in_valid && (pre >= DEPTH);
         e_fd  = 0;
         if (m_act && (cyc == m_start + CHAR)) begin
            e_fd  = m_last;
            m_act = 0;
         end
         if (!m_act && pre > 0) begin
`ifdef FRAME_HEADER_EN
            hdue = (m_pix == 0) && !m_hs;
`else
            hdue = 0;
`endif
            m_act   = 1;
            m_start = cyc;
            if (hdue) begin
               m_byte = 8'hA5;
               m_hs   = 1;
               m_last = 0;
            end else begin
               m_byte = q.pop_front();
               m_last = (m_pix == FP - 1);
               m_pix  = (m_pix + 1) % FP;
               if (m_last) m_hs = 0;
            end
         end
         if (in_valid && pre < DEPTH) q.push_back(in_data);
      end
   end

   // Per-cycle output checks and a line decoder independent of the model.
   bit         chk_en = 0;
   int         off;
   int         bi;
   logic       etx;
   int         ovf_seen = 0;
   int         fd_seen = 0;
   int         busy_cnt = 0;
   bit         d_act = 0;
   int         d_cnt = 0;
   logic [7:0] d_sh = 8'h00;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (chk_en) begin
         etx = 1'b1;
         if (m_act) begin
            off = cyc - m_start;
            bi  = off / CPB;
            if (bi == 0) etx = 1'b0;
            else if (bi <= 8) etx = m_byte[bi-1];
         end
         check("tx", tx, etx);
         check("busy", busy, m_act);
         check("in_ready", in_ready, q.size() < DEPTH);
         check("fifo_count", fifo_count, q.size());
         check("overflow", overflow, e_ovf);
         check("frame_done", frame_done, e_fd);
         ovf_seen += overflow;
         fd_seen  += frame_done;
         busy_cnt += busy;
         if (rst) begin
            d_act = 0;
         end else if (!d_act) begin
            if (tx == 1'b0) begin
               d_act = 1;
               d_cnt = 0;
            end
         end else begin
            d_cnt++;
            if (d_cnt == 5) check("start_bit", tx, 0);
            if ((d_cnt % CPB == 5) && d_cnt >= 15 && d_cnt < 95)
               d_sh[d_cnt/CPB-1] = tx;
            if (d_cnt == 95) begin
               check("stop_bit", tx, 1);
               rx_q.push_back(d_sh);
               d_act = 0;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #2 in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || fifo_count != 0) && n < budget);
      check("drain_timeout", busy || (fifo_count != 0), 0);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   logic [7:0] sent[$];
   logic [7:0] exp_q[$];
   int         n;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      chk_en = 1;
      #2;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 1);
      check("rst_count", fifo_count, 0);
      rst = 1'b0;
      ovf_seen = 0;
      fd_seen  = 0;
      repeat (50) @(posedge clk);
      #2;
      check("idle_ovf", ovf_seen, 0);
      check("idle_fd", fd_seen, 0);

      // Single character 0x55.
      rx_q.delete();
      busy_cnt = 0;
      push(8'h55);
      wait_idle(300);
`ifndef FRAME_HEADER_EN
      check("t2_rx_n", rx_q.size(), 1);
      if (rx_q.size() > 0) check("t2_rx", rx_q[0], 8'h55);
      check("t2_busy_len", busy_cnt, CHAR);
`endif

      // in_valid held 20 cycles against a 16-deep FIFO.
      rx_q.delete();
      sent.delete();
      busy_cnt = 0;
      ovf_seen = 0;
      acc_cnt  = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'($urandom);
         sent.push_back(in_data);
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      wait_idle(2500);
`ifndef FRAME_HEADER_EN
      check("t3_accepted", acc_cnt, 17);
      check("t3_overflows", ovf_seen, 3);
      check("t3_busy_len", busy_cnt, 17 * CHAR);
      check("t3_rx_n", rx_q.size(), 17);
      n = (rx_q.size() < 17) ? rx_q.size() : 17;
      for (int i = 0; i < n; i++) check("t3_rx", rx_q[i], sent[i]);
`endif

      // Frame framing with FRAME_PIXELS=4.
      do_reset();
      rx_q.delete();
      fd_seen = 0;
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 8'(i);
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      wait_idle(1500);
      exp_q.delete();
      for (int i = 1; i <= 8; i++) begin
`ifdef FRAME_HEADER_EN
         if (i % FP == 1) exp_q.push_back(8'hA5);
`endif
         exp_q.push_back(8'(i));
      end
      check("t4_rx_n", rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("t4_rx", rx_q[i], exp_q[i]);
      check("t4_frames", fd_seen, 2);

      // Reset during data bit 3.
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'hC3;
      @(posedge clk);
      #2 in_data = 8'h12;
      @(posedge clk);
      #2 in_data = 8'h34;
      @(posedge clk);
      #2 in_valid = 1'b0;
      repeat (42) @(posedge clk);
      #1 check("t5_busy_pre", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_tx_async", tx, 1);
      check("t5_count", fifo_count, 0);
      check("t5_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      rx_q.delete();
      push(8'h0F);
      wait_idle(500);
      exp_q.delete();
`ifdef FRAME_HEADER_EN
      exp_q.push_back(8'hA5);
`endif
      exp_q.push_back(8'h0F);
      check("t5_rx_n", rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("t5_rx", rx_q[i], exp_q[i]);

      // Push attempted on the pop edge with the FIFO full.
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 20);
      check("t6_start", busy, 1);
      repeat (CHAR) @(posedge clk);
      @(negedge clk);
      check("t6_count", fifo_count, 15);
      check("t6_ovf", overflow, 1);
      @(posedge clk);
      #2 in_valid = 1'b0;
      wait_idle(2500);

      // Random traffic in three load regimes.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         in_valid = ($urandom_range(0, 99) < ((i < 500) ? 8 :
                                              (i < 1000) ? 70 : 2));
         in_data  = 8'($urandom);
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      wait_idle(2500);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
